// File: rtl/loader_pkg.sv
// Shared defaults and state encoding for the boot-time IM program loader.
package loader_pkg;

    localparam int DATA_SIZE_DEF = 32;
    localparam int MEM_SIZE_DEF  = 10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD   = S_LOAD,
        ST_VERIFY = S_VERIFY,
        ST_DONE   = S_DONE,
        ST_ERROR  = S_ERROR
    } loader_state_e;

endpackage

// File: rtl/im_port_mux.sv
// IM port ownership mux: the CPU fetch path drives IM once released, otherwise the loader does.
// Loader-side controls are gated so an idle loader presents an all-zero port.
module im_port_mux
    import loader_pkg::*;
#(
    parameter int DataSize = DATA_SIZE_DEF,
    parameter int MemSize  = MEM_SIZE_DEF
) (
    input  logic                cpu_own_i,
    input  logic [MemSize-1:0]  ld_addr_i,
    input  logic                ld_read_i,
    input  logic                ld_write_i,
    input  logic [DataSize-1:0] ld_data_i,
    input  logic [MemSize-1:0]  cpu_pc_i,
    input  logic                cpu_read_i,
    input  logic                cpu_en_i,
    output logic [MemSize-1:0]  im_addr_o,
    output logic                im_read_o,
    output logic                im_write_o,
    output logic                im_enable_o,
    output logic [DataSize-1:0] im_wdata_o
);

    always_comb begin
        im_addr_o   = '0;
        im_read_o   = 1'b0;
        im_write_o  = 1'b0;
        im_enable_o = 1'b0;
        im_wdata_o  = '0;
        if (cpu_own_i) begin
            im_addr_o   = cpu_pc_i;
            im_read_o   = cpu_read_i;
            im_enable_o = cpu_en_i;
        end else if (ld_read_i || ld_write_i) begin
            im_addr_o   = ld_addr_i;
            im_read_o   = ld_read_i;
            im_write_o  = ld_write_i;
            im_enable_o = 1'b1;
            if (ld_write_i) begin
                im_wdata_o = ld_data_i;
            end
        end
    end

endmodule

// File: rtl/im_prog_loader.sv
// Boot-time program loader: streams words into IM from address 0, then releases the CPU.
// Optional read-back checksum verification is enabled with the LOADER_VERIFY_EN macro.
module im_prog_loader
    import loader_pkg::*;
#(
    parameter int DataSize = DATA_SIZE_DEF,
    parameter int MemSize  = MEM_SIZE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DataSize-1:0] in_data,
    input  logic                in_last,
    input  logic [MemSize-1:0]  cpu_PC,
    input  logic                cpu_IM_read,
    input  logic                cpu_IM_en,
    output logic [MemSize-1:0]  IM_address,
    output logic                IM_read,
    output logic                IM_write,
    output logic                IM_enable,
    output logic [DataSize-1:0] IMin,
    input  logic [DataSize-1:0] IM_out,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [MemSize:0]    word_cnt,
    output logic [2:0]          dbg_state
);

    localparam logic [MemSize-1:0] PTR_MAX = '1;
    localparam logic [MemSize-1:0] PTR_ONE = {{(MemSize-1){1'b0}}, 1'b1};
    localparam logic [MemSize:0]   CNT_ONE = {{MemSize{1'b0}}, 1'b1};

    loader_state_e       state_q, state_d;
    logic [MemSize-1:0]  ptr_q, ptr_d;
    logic [MemSize:0]    cnt_q, cnt_d;
    logic [DataSize-1:0] csum_q, csum_d;
    logic                wr_pend_q, wr_pend_d;
    logic [MemSize-1:0]  wr_addr_q, wr_addr_d;
    logic [DataSize-1:0] wr_data_q, wr_data_d;
    logic                fin_q, fin_d;
    logic                ovf_q, ovf_d;
    logic                accept;
    logic                rd_issue;
    logic [MemSize-1:0]  rd_addr;

`ifdef LOADER_VERIFY_EN
    logic [MemSize:0]    rd_cnt_q, rd_cnt_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DataSize-1:0] vsum_q, vsum_d;
`else
    logic unused_im_out;
    assign unused_im_out = ^IM_out;
`endif

    // Stop accepting once the final or overflowing word is in its write cycle.
    assign in_ready = (state_q == ST_LOAD) && !fin_q && !ovf_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fin_d     = fin_q;
        ovf_d     = ovf_q;
        rd_issue  = 1'b0;
        rd_addr   = '0;
`ifdef LOADER_VERIFY_EN
        rd_cnt_d  = rd_cnt_q;
        rd_vld_d  = 1'b0;
        vsum_d    = vsum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    csum_d  = '0;
                    fin_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_data;
                    ptr_d     = ptr_q + PTR_ONE;
                    cnt_d     = cnt_q + CNT_ONE;
                    csum_d    = csum_q ^ in_data;
                    if (in_last) begin
                        fin_d = 1'b1;
                    end else if (ptr_q == PTR_MAX) begin
                        ovf_d = 1'b1;
                    end
                end
                if (fin_q) begin
`ifdef LOADER_VERIFY_EN
                    state_d  = ST_VERIFY;
                    rd_cnt_d = '0;
                    vsum_d   = '0;
`else
                    state_d  = ST_DONE;
`endif
                end else if (ovf_q) begin
                    state_d = ST_ERROR;
                end
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (rd_cnt_q != cnt_q) begin
                    rd_issue = 1'b1;
                    rd_addr  = rd_cnt_q[MemSize-1:0];
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                    rd_vld_d = 1'b1;
                end
                // IM_out carries the datum of the read issued last cycle.
                if (rd_vld_q) begin
                    vsum_d = vsum_q ^ IM_out;
                    if (rd_cnt_q == cnt_q) begin
                        state_d = (vsum_d == csum_q) ? ST_DONE : ST_ERROR;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            fin_q     <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef LOADER_VERIFY_EN
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            vsum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fin_q     <= fin_d;
            ovf_q     <= ovf_d;
`ifdef LOADER_VERIFY_EN
            rd_cnt_q  <= rd_cnt_d;
            rd_vld_q  <= rd_vld_d;
            vsum_q    <= vsum_d;
`endif
        end
    end

    assign cpu_hold   = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign load_error = (state_q == ST_ERROR);
    assign word_cnt   = cnt_q;
    assign dbg_state  = state_q;

    im_port_mux #(
        .DataSize (DataSize),
        .MemSize  (MemSize)
    ) u_port_mux (
        .cpu_own_i   (!cpu_hold),
        .ld_addr_i   (rd_issue ? rd_addr : wr_addr_q),
        .ld_read_i   (rd_issue),
        .ld_write_i  (wr_pend_q),
        .ld_data_i   (wr_data_q),
        .cpu_pc_i    (cpu_PC),
        .cpu_read_i  (cpu_IM_read),
        .cpu_en_i    (cpu_IM_en),
        .im_addr_o   (IM_address),
        .im_read_o   (IM_read),
        .im_write_o  (IM_write),
        .im_enable_o (IM_enable),
        .im_wdata_o  (IMin)
    );

endmodule

// File: tb/tb_im_prog_loader.sv
// Bench for im_prog_loader with a 16-word IM model; build with LOADER_VERIFY_EN to cover read-back.
module tb_im_prog_loader;

  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int DEPTH = 1 << MW;
  localparam int EW    = 32 + MW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset, load_start, in_valid, in_ready, in_last;
  logic [DW-1:0] in_data, IMin, IM_out;
  logic [MW-1:0] cpu_PC, IM_address;
  logic          cpu_IM_read, cpu_IM_en, IM_read, IM_write, IM_enable;
  logic          cpu_hold, load_done, load_error;
  logic [MW:0]   word_cnt;
  logic [2:0]    dbg_state;

  im_prog_loader #(.DataSize(DW), .MemSize(MW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cpu_PC(cpu_PC), .cpu_IM_read(cpu_IM_read), .cpu_IM_en(cpu_IM_en),
    .IM_address(IM_address), .IM_read(IM_read), .IM_write(IM_write),
    .IM_enable(IM_enable), .IMin(IMin), .IM_out(IM_out),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .word_cnt(word_cnt), .dbg_state(dbg_state)
  );

  // ---------------- IM model ----------------
  logic [DW-1:0] im_mem [DEPTH];
  logic [DW-1:0] im_out_q = '0;
  logic          corrupt_en;
  logic [MW-1:0] corrupt_addr;
  always @(posedge clk) begin
    if (IM_enable && IM_write) im_mem[IM_address] <= IMin;
    if (corrupt_en) im_mem[corrupt_addr] <= ~im_mem[corrupt_addr];
    if (IM_enable && IM_read) im_out_q <= im_mem[IM_address];
  end
  assign IM_out = im_out_q;

  // ---------------- reference model / scoreboard ----------------
  int            checks = 0;
  int            failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [DW-1:0] mdl_mem [DEPTH];
  int            m_ptr, m_cnt;
  logic [DW-1:0] m_csum;
  bit            m_ovf, m_corrupt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] im_xor(input int n);
    logic [DW-1:0] x = '0;
    for (int i = 0; i < n; i++) x ^= im_mem[i];
    return x;
  endfunction

  function automatic logic [DW-1:0] mdl_xor(input int n);
    logic [DW-1:0] x = '0;
    for (int i = 0; i < n; i++) x ^= mdl_mem[i];
    return x;
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_cnt = 0; m_csum = '0; m_ovf = 0; m_corrupt = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (IM_write) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write", IM_address, IMin);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_cycle", cyc, mon_e[EW-1 -: 32]);
        chk("wr_addr", 32'(IM_address), 32'(mon_e[DW +: MW]));
        chk("wr_data", IMin, mon_e[DW-1:0]);
        chk("wr_ctrl", 32'({IM_enable, IM_read}), 32'h2);
      end
    end else if (cpu_hold) begin
`ifdef LOADER_VERIFY_EN
      chk("idle_port", 32'({IM_enable ^ IM_read, IMin != '0}), 32'h0);
`else
      chk("idle_port", 32'({IM_enable, IM_read, IM_address != '0, IMin != '0}), 32'h0);
`endif
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic rand_cpu();
    cpu_PC      = MW'($urandom_range(0, DEPTH - 1));
    cpu_IM_read = 1'($urandom_range(0, 1));
    cpu_IM_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    model_clear();
    chk("start_word_cnt", 32'(word_cnt), 32'h0);
    chk("start_done", 32'(load_done), 32'h0);
    chk("start_hold", 32'(cpu_hold), 32'h1);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit last);
    in_valid = 1'b1; in_data = d; in_last = last;
    rand_cpu();
    @(negedge clk);
    chk("in_ready_load", 32'(in_ready), 32'h1);
    exp_q.push_back({cyc + 32'd1, m_ptr[MW-1:0], d});
    mdl_mem[m_ptr] = d;
    if (m_ptr == DEPTH - 1 && !last) m_ovf = 1;
    m_ptr++; m_cnt++; m_csum ^= d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic idle(input int n, input bit pulse);
    for (int i = 0; i < n; i++) begin
      load_start = pulse && (i == 0);
      rand_cpu();
      @(posedge clk); #1;
      load_start = 1'b0;
    end
  endtask

  // n0 = clock edges already elapsed since the final accept edge (inclusive).
  task automatic finish_load(input int n0);
    int n; bit seen; bit exp_err; int exp_lat;
    n = n0; seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (m_ovf && k == 0) chk("ovf_in_ready", 32'(in_ready), 32'h0);
      if (load_done || load_error) seen = 1;
      else begin
        @(posedge clk); n++;
      end
    end
    exp_err = m_ovf;
    exp_lat = 2;
`ifdef LOADER_VERIFY_EN
    if (!m_ovf) begin
      exp_err = (mdl_xor(m_cnt) != m_csum);
      exp_lat = 2 + m_cnt + 1;
    end
`endif
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout: actual no load_done/load_error within 64 cycles, required one");
    end else begin
      chk("done_latency", n, exp_lat);
      chk("load_done", 32'(load_done), 32'(!exp_err));
      chk("load_error", 32'(load_error), 32'(exp_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(exp_err));
      chk("word_cnt", 32'(word_cnt), m_cnt);
      chk("in_ready_end", 32'(in_ready), 32'h0);
      chk("exp_q_drained", exp_q.size(), 32'h0);
      for (int a = 0; a < m_cnt; a++) chk("im_content", im_mem[a], mdl_mem[a]);
      chk("im_checksum", im_xor(m_cnt), m_csum ^ (m_corrupt ? (mdl_mem[2] ^ ~mdl_mem[2]) : '0));
    end
    @(posedge clk); #1;
  endtask

  task automatic cpu_check(input int n);
    for (int i = 0; i < n; i++) begin
      rand_cpu();
      #1;
      chk("pass_addr", 32'(IM_address), 32'(cpu_PC));
      chk("pass_read", 32'(IM_read), 32'(cpu_IM_read));
      chk("pass_en", 32'(IM_enable), 32'(cpu_IM_en));
      chk("pass_write", 32'(IM_write), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual sim still running, required completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cpu_PC = '0; cpu_IM_read = 1'b0; cpu_IM_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = '0;
    model_clear();

    @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'h1);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_im_enable", 32'(IM_enable), 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    chk("rst_error", 32'(load_error), 32'h0);
    chk("rst_word_cnt", 32'(word_cnt), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // back-to-back program
    start_load();
    send_word(32'h0A, 0); send_word(32'h0B, 0); send_word(32'h0C, 1);
    finish_load(1);
    cpu_check(4);

    // asynchronous reset from DONE with the CPU driving the port
    cpu_IM_en = 1'b1; cpu_IM_read = 1'b1;
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_hold", 32'(cpu_hold), 32'h1);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    chk("arst_im_enable", 32'(IM_enable), 32'h0);
    chk("arst_done", 32'(load_done), 32'h0);
    chk("arst_error", 32'(load_error), 32'h0);
    chk("arst_word_cnt", 32'(word_cnt), 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // gapped program, stray load_start mid-load
    start_load();
    send_word(32'h0A, 0); idle(2, 1);
    send_word(32'h0B, 0); idle(2, 0);
    send_word(32'h0C, 1);
    finish_load(1);
    chk("gap_checksum", im_xor(3), 32'h0D);
    cpu_check(2);

    // overflow: full depth, no last
    start_load();
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    finish_load(1);

    // reset after two of five words, then a fresh load
    start_load();
    send_word($urandom, 0); send_word($urandom, 0);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'h0);
    chk("mid_rst_write", 32'(IM_write), 32'h0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    start_load();
    send_word($urandom, 0); send_word($urandom, 0); send_word($urandom, 1);
    finish_load(1);

`ifdef LOADER_VERIFY_EN
    // corrupt one stored word before read-back
    start_load();
    for (int i = 0; i < 4; i++) send_word($urandom, i == 3);
    corrupt_en = 1'b1; corrupt_addr = MW'(2);
    mdl_mem[2] = ~mdl_mem[2];
    m_corrupt = 1;
    @(posedge clk); #1 corrupt_en = 1'b0;
    finish_load(2);
`endif

    // randomized programs
    for (int r = 0; r < 6; r++) begin
      int len;
      len = (r == 0) ? DEPTH : $urandom_range(1, DEPTH);
      start_load();
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2), 0);
        send_word($urandom, i == len - 1);
      end
      finish_load(1);
      cpu_check(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
